clk_div_prog: RTL and testbench

//  Runtime-programmable clock divider, successor to the fixed divide-by-2N clk_div.

---
 rtl/clk_div_pkg.sv | 25 ++
 rtl/clk_div_ratio_reg.sv | 55 +++++
 rtl/clk_div_prog.sv | 131 +++++++++++++
 tb/tb_clk_div_prog.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// ============================================================================
// Module  : clk_div_pkg
// Brief   : Shared state encoding, minimum ratio and ratio clamp for clk_div_prog.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } clk_div_state_t;

  localparam int CLK_DIV_MIN = 2;

  // Ratios below the minimum cannot form both a high and a low phase.
  function automatic logic [31:0] clamp_div(input logic [31:0] val);
    return (val < 32'(CLK_DIV_MIN)) ? 32'(CLK_DIV_MIN) : val;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clk_div_ratio_reg.sv
// ============================================================================
// Module  : clk_div_ratio_reg
// Brief   : Pending/active divide-ratio registers; a loaded ratio waits in
//           pending_div and moves to active_div on the next period boundary.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_ratio_reg
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_div_val,
  input  logic             i_load,
  input  logic             i_apply,
  output logic [WIDTH-1:0] o_active_div,
  output logic             o_pend
);

  logic [WIDTH-1:0] r_active_div;
  logic [WIDTH-1:0] r_pending_div;
  logic             r_pend;
  logic [WIDTH-1:0] w_clamped;

  assign w_clamped = WIDTH'(clamp_div(32'(i_div_val)));

  // A load coinciding with a boundary keeps the flag set, so it lands at the following one.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_active_div  <= WIDTH'(DEFAULT_DIV);
      r_pending_div <= WIDTH'(DEFAULT_DIV);
      r_pend        <= 1'b0;
    end else begin
      if (i_apply && r_pend) begin
        r_active_div <= r_pending_div;
      end
      if (i_load) begin
        r_pending_div <= w_clamped;
        r_pend        <= 1'b1;
      end else if (i_apply) begin
        r_pend <= 1'b0;
      end
    end
  end

  assign o_active_div = r_active_div;
  assign o_pend       = r_pend;

endmodule

`default_nettype wire

// File: rtl/clk_div_prog.sv
// ============================================================================
// Module  : clk_div_prog
// Brief   : Runtime-programmable glitch-free clock divider with per-period tick.
//           Optional phase realign input enabled by defining CLKDIV_SYNC_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_load,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync_in,
`endif
  output logic             clk_out,
  output logic             tick,
  output logic             div_pend
);

  clk_div_state_t   r_state;
  clk_div_state_t   w_state_nxt;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             r_clk_out;
  logic             w_clk_nxt;
  logic             r_tick;
  logic             w_tick_nxt;
  logic             w_apply;
  logic             w_sync;
  logic             w_wrap;
  logic [WIDTH-1:0] w_active_div;
  logic [WIDTH:0]   w_hi;
  logic [WIDTH:0]   w_cnt_inc;

`ifdef CLKDIV_SYNC_EN
  assign w_sync = sync_in;
`else
  assign w_sync = 1'b0;
`endif

  clk_div_ratio_reg #(
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_ratio (
    .clk          (clk),
    .i_rst_n      (reset),
    .i_div_val    (div_val),
    .i_load       (div_load),
    .i_apply      (w_apply),
    .o_active_div (w_active_div),
    .o_pend       (div_pend)
  );

  // Odd ratios give the extra cycle to the high phase.
  assign w_hi      = ({1'b0, w_active_div} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
  assign w_cnt_inc = {1'b0, r_cnt} + {{WIDTH{1'b0}}, 1'b1};
  assign w_wrap    = (r_cnt == (w_active_div - {{(WIDTH-1){1'b0}}, 1'b1}));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clk_nxt   = r_clk_out;
    w_tick_nxt  = 1'b0;
    w_apply     = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        w_clk_nxt = 1'b0;
        if (en) begin
          w_state_nxt = RUN;
          w_clk_nxt   = 1'b1;
          w_tick_nxt  = 1'b1;
          w_apply     = 1'b1;
        end
      end
      RUN, DRAIN: begin
        if (w_wrap || (w_sync && (r_state == RUN))) begin
          w_cnt_nxt = '0;
          w_apply   = 1'b1;
          if (en) begin
            w_state_nxt = RUN;
            w_clk_nxt   = 1'b1;
            w_tick_nxt  = 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_clk_nxt   = 1'b0;
          end
        end else begin
          w_cnt_nxt = w_cnt_inc[WIDTH-1:0];
          w_clk_nxt = (w_cnt_inc < w_hi);
          if (!en) begin
            w_state_nxt = DRAIN;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_clk_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_clk_out <= w_clk_nxt;
      r_tick    <= w_tick_nxt;
    end
  end

  assign clk_out = r_clk_out;
  assign tick    = r_tick;

endmodule

`default_nettype wire

// File: tb/tb_clk_div_prog.sv
// ============================================================================
// Module  : tb_clk_div_prog
// Brief   : Directed self-checking bench for clk_div_prog (sync test only
//           when CLKDIV_SYNC_EN is defined).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_div_prog;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             en;
  logic [WIDTH-1:0] div_val;
  logic             div_load;
  logic             sync_in;
  logic             clk_out;
  logic             tick;
  logic             div_pend;

  int n_checks = 0;
  int n_errors = 0;

  clk_div_prog #(
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .div_val  (div_val),
    .div_load (div_load),
`ifdef CLKDIV_SYNC_EN
    .sync_in  (sync_in),
`endif
    .clk_out  (clk_out),
    .tick     (tick),
    .div_pend (div_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Patterns are listed oldest sample first (MSB of the n-bit field).
  task automatic expect_seq(input string tag, input int n,
                            input logic [31:0] cp, input logic [31:0] tp);
    for (int i = 0; i < n; i++) begin
      step();
      check($sformatf("%s[%0d].clk_out", tag, i), {31'd0, clk_out}, {31'd0, cp[n-1-i]});
      check($sformatf("%s[%0d].tick", tag, i), {31'd0, tick}, {31'd0, tp[n-1-i]});
    end
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    div_val  = v;
    div_load = 1'b1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; en = 1'b1; div_val = '0; div_load = 1'b0; sync_in = 1'b0;
    #2;
    check("rst.clk_out", {31'd0, clk_out}, 32'd0);
    check("rst.tick", {31'd0, tick}, 32'd0);
    check("rst.div_pend", {31'd0, div_pend}, 32'd0);
    step(); step();
    reset = 1'b1;

    // Default N=2
    expect_seq("n2", 3, 32'b101, 32'b101);
    en = 1'b0;
    expect_seq("stop2", 3, 32'b000, 32'b000);

    // N=4 loaded in IDLE
    load(8'd4);
    step();
    div_load = 1'b0; en = 1'b1;
    check("n4.pend_idle", {31'd0, div_pend}, 32'd1);
    expect_seq("n4", 8, 32'b11001100, 32'b10001000);
    check("n4.pend_done", {31'd0, div_pend}, 32'd0);

    // Load N=6 while running N=4 at cnt=1
    expect_seq("n4b", 2, 32'b11, 32'b10);
    load(8'd6);
    step();
    div_load = 1'b0;
    check("n6.clk_cnt2", {31'd0, clk_out}, 32'd0);
    check("n6.pend_a", {31'd0, div_pend}, 32'd1);
    step();
    check("n6.pend_b", {31'd0, div_pend}, 32'd1);
    expect_seq("n6", 7, 32'b1110001, 32'b1000001);
    check("n6.pend_done", {31'd0, div_pend}, 32'd0);

    // Drop en at cnt=1 of a 6-cycle period
    step();
    check("drain.cnt1", {31'd0, clk_out}, 32'd1);
    en = 1'b0;
    expect_seq("drain", 6, 32'b100000, 32'b000000);

    // N=5
    load(8'd5);
    step();
    div_load = 1'b0; en = 1'b1;
    expect_seq("n5", 10, 32'b1110011100, 32'b1000010000);

    // Load 0 on a wrap edge: clamps to 2, applies one period later
    load(8'd0);
    step();
    div_load = 1'b0;
    check("ld0.clk", {31'd0, clk_out}, 32'd1);
    check("ld0.tick", {31'd0, tick}, 32'd1);
    check("ld0.pend", {31'd0, div_pend}, 32'd1);
    expect_seq("ld0", 7, 32'b1100101, 32'b0000101);
    check("ld0.pend_done", {31'd0, div_pend}, 32'd0);

    // Two loads before the boundary: last one wins
    en = 1'b0;
    step();
    check("lw.drain", {31'd0, clk_out}, 32'd0);
    load(8'd3);
    step();
    check("lw.idle", {31'd0, clk_out}, 32'd0);
    load(8'd7);
    step();
    div_load = 1'b0; en = 1'b1;
    check("lw.pend", {31'd0, div_pend}, 32'd1);
    expect_seq("n7", 8, 32'b11110001, 32'b10000001);

    // Reset mid-high phase drops a pending ratio
    load(8'd9);
    step();
    div_load = 1'b0;
    check("rst2.high", {31'd0, clk_out}, 32'd1);
    check("rst2.pend", {31'd0, div_pend}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rst2.clk_out", {31'd0, clk_out}, 32'd0);
    check("rst2.pend_clr", {31'd0, div_pend}, 32'd0);
    step();
    reset = 1'b1;
    expect_seq("rst2.n2", 4, 32'b1010, 32'b1010);

`ifdef CLKDIV_SYNC_EN
    // N=8 (load lands on a wrap, applies the wrap after), sync at cnt=3
    load(8'd8);
    step();
    div_load = 1'b0;
    step();
    step();
    check("sync.wrap_clk", {31'd0, clk_out}, 32'd1);
    check("sync.wrap_tick", {31'd0, tick}, 32'd1);
    expect_seq("sync.pre", 3, 32'b111, 32'b000);
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    check("sync.clk", {31'd0, clk_out}, 32'd1);
    check("sync.tick", {31'd0, tick}, 32'd1);
    expect_seq("sync.post", 4, 32'b1110, 32'b0000);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
